// File: rtl/conv_sched_if.sv
// Control/engine bundle for conv_sched: run control, status, and the job
// start/finish handshake toward the 3x3 convolution engine.
interface conv_sched_if #(
  parameter int CW = 4
);
  logic              start;
  logic              abort;
  logic [CW:0]       cfg_w;
  logic [CW:0]       cfg_h;
  logic              eng_start;
  logic [CW-1:0]     eng_x;
  logic [CW-1:0]     eng_y;
  logic              eng_finish;
  logic              busy;
  logic              done;
  logic              err;
  logic [2*CW-1:0]   job_cnt;

  modport master (
    output start, abort, cfg_w, cfg_h, eng_finish,
    input  eng_start, eng_x, eng_y, busy, done, err, job_cnt
  );

  modport slave (
    input  start, abort, cfg_w, cfg_h, eng_finish,
    output eng_start, eng_x, eng_y, busy, done, err, job_cnt
  );
endinterface

// File: rtl/conv_sched.sv
// Raster job scheduler for the 3x3 conv engine: one start/finish job per valid
// output position of a cfg_w x cfg_h map (no padding), x fastest.
module conv_sched #(
  parameter int CW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  conv_sched_if.slave bus
);
  localparam int CW1 = CW + 1;
  localparam int TW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_WARN = TW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_FIN
  } state_t;

  state_t            r_state, w_nxt;
  logic [CW:0]       r_cfg_w, r_cfg_h;
  logic [CW-1:0]     r_x, r_y, w_x, w_y;
  logic [2*CW-1:0]   r_cnt, w_cnt;
  logic [TW-1:0]     r_tmo, w_tmo;
  logic              r_err, w_err;
  logic              r_busy, r_eng_start, r_done;
  logic              w_ld_cfg;
  logic [CW:0]       w_xmax, w_ymax;
  logic              w_x_last, w_y_last;

  // Last window origin is dim-3, evaluated at CW+1 bits
  assign w_xmax   = r_cfg_w - CW1'(3);
  assign w_ymax   = r_cfg_h - CW1'(3);
  assign w_x_last = ({1'b0, r_x} == w_xmax);
  assign w_y_last = ({1'b0, r_y} == w_ymax);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt    = r_state;
    w_x      = r_x;
    w_y      = r_y;
    w_cnt    = r_cnt;
    w_tmo    = r_tmo;
    w_err    = r_err;
    w_ld_cfg = 1'b0;
    if (r_state != S_IDLE && bus.abort) begin
      w_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            w_nxt    = S_CHECK;
            w_ld_cfg = 1'b1;
            w_err    = 1'b0;
            w_cnt    = '0;
            w_x      = '0;
            w_y      = '0;
          end
        end
        S_CHECK: begin
          if (r_cfg_w < CW1'(3) || r_cfg_h < CW1'(3)) begin
            w_err = 1'b1;
            w_nxt = S_FIN;
          end else begin
            w_nxt = S_ISSUE;
          end
        end
        S_ISSUE: begin
          w_tmo = '0;
          w_nxt = S_WAIT;
        end
        S_WAIT: begin
          w_tmo = r_tmo + 1'b1;
          // err is already visible in this cycle; leave regardless of finish
          if (r_tmo == TMO_LAST) begin
            w_nxt = S_FIN;
          end else if (bus.eng_finish) begin
            w_cnt = r_cnt + 1'b1;
            if (w_x_last && w_y_last) begin
              w_nxt = S_FIN;
            end else begin
              w_nxt = S_ISSUE;
              if (w_x_last) begin
                w_x = '0;
                w_y = r_y + 1'b1;
              end else begin
                w_x = r_x + 1'b1;
              end
            end
          end else if (r_tmo == TMO_WARN) begin
            w_err = 1'b1;
          end
        end
        S_FIN:   w_nxt = S_IDLE;
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state decode so they align with the state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cfg_w     <= '0;
      r_cfg_h     <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_eng_start <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_ld_cfg) begin
        r_cfg_w <= bus.cfg_w;
        r_cfg_h <= bus.cfg_h;
      end
      r_x         <= w_x;
      r_y         <= w_y;
      r_cnt       <= w_cnt;
      r_tmo       <= w_tmo;
      r_err       <= w_err;
      r_busy      <= (w_nxt != S_IDLE);
      r_eng_start <= (w_nxt == S_ISSUE);
      r_done      <= (w_nxt == S_FIN);
    end
  end

  assign bus.eng_start = r_eng_start;
  assign bus.eng_x     = r_x;
  assign bus.eng_y     = r_y;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.job_cnt   = r_cnt;
endmodule

// File: doc/conv_sched.md
# conv_sched

Job scheduler for the 3x3 convolution engine (`conv`). It walks every valid output position of a `cfg_w` x `cfg_h` feature map with no padding. For each position it issues one engine job, waits for the engine's `finish`, then advances to the next position. It sits between the top-level control register block and the `conv` start/finish handshake, supplies the window origin used for address generation, and reports completion, progress and errors.

## Interface
- `CW`, default 4: coordinate width. The map dimension limit is 2^CW.
- `TIMEOUT`, default 64: maximum WAIT cycles per job before an error is flagged.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  pulse that requests a run. Honoured only in IDLE.
- `abort`  in  1  synchronous abort. Highest priority.
- `cfg_w`  in  CW+1  map width. Sampled on the accepted `start`.
- `cfg_h`  in  CW+1  map height. Sampled on the accepted `start`.
- `eng_start`  out  1  one-cycle job request to `conv`.
- `eng_x`  out  CW  window origin column for the current job.
- `eng_y`  out  CW  window origin row for the current job.
- `eng_finish`  in  1  job-complete pulse from `conv`.
- `busy`  out  1  high from the accepted `start` until `done` or abort.
- `done`  out  1  one-cycle run-complete pulse.
- `err`  out  1  sticky error flag. Cleared by the next accepted `start`.
- `job_cnt`  out  2*CW  number of jobs completed in the current run.

## Operation
- Reset: state returns to IDLE. All outputs reset to 0.
- States: IDLE, CHECK, ISSUE, WAIT, FIN.
- IDLE:
  - On `start` with `abort` low, latch `cfg_w`/`cfg_h`, clear `err`, `job_cnt`, `eng_x` and `eng_y`, set `busy`, and go to CHECK.
- CHECK:
  - If `cfg_w < 3` or `cfg_h < 3`, set `err` and go to FIN. No job is issued.
  - Otherwise go to ISSUE.
- ISSUE:
  - Assert `eng_start` for exactly one cycle.
  - Clear the timeout counter and go to WAIT.
- WAIT:
  - `eng_x`/`eng_y` are held stable.
  - The timeout counter increments every cycle.
  - On `eng_finish`, increment `job_cnt`.
    - If the position is the last one (`eng_x == cfg_w-3` and `eng_y == cfg_h-3`), go to FIN.
    - Otherwise, if `eng_x == cfg_w-3`, wrap `eng_x` to 0 and increment `eng_y`; else increment `eng_x`. Then go to ISSUE.
  - If the counter reaches TIMEOUT-1 with no `eng_finish`, set `err` and go to FIN.
- FIN: pulse `done`, clear `busy`, go to IDLE.
- Job count per run is (cfg_w-2)*(cfg_h-2). Scan order is raster: x fastest.
- `eng_finish` outside WAIT is ignored. This includes the cycle in which `eng_start` is high.
- `start` while `busy` is ignored, with no effect on state or configuration.
- `abort` in any non-IDLE state:
  - Go to IDLE next cycle and clear `busy`.
  - No `done` pulse is produced.
  - `err`, `job_cnt` and the coordinates keep their values.
- Simultaneous events:
  - `abort` together with `eng_finish`: abort wins and `job_cnt` is not incremented.
  - `start` together with `abort` in IDLE: the run does not start.
- Reset asserted mid-run: immediate return to IDLE. `eng_start` and `done` drop asynchronously.
- Arithmetic:
  - All comparisons are unsigned.
  - `cfg_w-3` and `cfg_h-3` are computed at CW+1 bits.
  - Values above 2^CW are out of scope and undefined.

## Timing
- Cycle 0 (accepted `start`) → cycle 1 CHECK → cycle 2 ISSUE with `eng_start`=1 and `eng_x`=`eng_y`=0.
- `eng_finish` in cycle n (WAIT) → ISSUE in cycle n+1, with the next coordinates already valid.
  - Turnaround is one cycle between finish and the next `eng_start`.
- Last `eng_finish` in cycle n → `done`=1 in cycle n+1; `busy`=0 from cycle n+2.
- Illegal configuration → `done` in cycle 2 with `err`=1.
- Timeout → `err` rises at the WAIT cycle when the counter reaches TIMEOUT-1. `done` follows one cycle later.
- All outputs are registered. No combinational path from input to output.

## Test plan
- `cfg_w`=5, `cfg_h`=4, engine finishes 3 cycles after each `eng_start`:
  - 6 jobs in the order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1).
  - `done` one cycle after the 6th finish; `job_cnt`=6, `err`=0.
- `cfg_w`=`cfg_h`=3: exactly one `eng_start` at (0,0). `done` follows its finish by one cycle.
- `cfg_w`=2, `cfg_h`=8: no `eng_start`. `done` and `err`=1 in cycle 2. A following valid `start` clears `err`.
- `eng_finish` never returned with TIMEOUT=64: `err`=1 after 63 WAIT cycles, `done` on the next cycle, `job_cnt`=0.
- `cfg_w`=`cfg_h`=6:
  - `abort` coincident with the 3rd `eng_finish` → IDLE, no `done`, `job_cnt`=2.
  - `start` pulses issued mid-run are ignored.
- `rst` asserted during WAIT of job 4: all outputs 0 immediately. A later `start` restarts from (0,0) with `job_cnt`=0.
